// File: rtl/bus_demux1t2_pkg.sv
// Shared definitions for the data-bus 1-to-2 request demultiplexer:
// FSM encoding, default s1 address window and timeout counter width.
package bus_demux1t2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DEF_S1_BASE = 32'h1000_0000;
    localparam logic [31:0] DEF_S1_MASK = 32'hF000_0000;

    // Timeout counter width; TIMEOUT must fit (1..255).
    localparam int CNT_W = 8;

endpackage

// File: rtl/mul2t1.sv
// Two-input multiplexer: y = sel ? d1 : d0.
module mul2t1 #(
    parameter int data_width = 32
) (
    input  logic                  sel,
    input  logic [data_width-1:0] d0,
    input  logic [data_width-1:0] d1,
    output logic [data_width-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/bus_demux1t2.sv
// Routes one master data-bus request to the RAM (s0) or peripheral (s1)
// target by address window; one transaction outstanding at a time.
module bus_demux1t2
    import bus_demux1t2_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] S1_BASE = DATA_W'(DEF_S1_BASE),
    parameter logic [DATA_W-1:0] S1_MASK = DATA_W'(DEF_S1_MASK),
    parameter int                TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m_req_valid,
    output logic              m_req_ready,
    input  logic [DATA_W-1:0] m_addr,
    input  logic              m_wen,
    input  logic [3:0]        m_be,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_rsp_valid,
    output logic              m_rsp_err,
    output logic [DATA_W-1:0] m_rdata,

    output logic              s0_req_valid,
    input  logic              s0_req_ready,
    output logic [DATA_W-1:0] s0_addr,
    output logic              s0_wen,
    output logic [3:0]        s0_be,
    output logic [DATA_W-1:0] s0_wdata,
    input  logic              s0_rsp_valid,
    input  logic [DATA_W-1:0] s0_rdata,

    output logic              s1_req_valid,
    input  logic              s1_req_ready,
    output logic [DATA_W-1:0] s1_addr,
    output logic              s1_wen,
    output logic [3:0]        s1_be,
    output logic [DATA_W-1:0] s1_wdata,
    input  logic              s1_rsp_valid,
    input  logic [DATA_W-1:0] s1_rdata,

    output logic [1:0]        fsm_state
);

    // Handshakes: a request moves when valid and ready are both high at a
    // rising edge; responses are single-cycle pulses with no back-pressure.

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_t            state;
    state_t            next_state;

    logic              ready_q;
    logic              sel_q;
    logic [DATA_W-1:0] addr_q;
    logic              wen_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic              hit_s1;
    logic              tgt_req_ready;
    logic              tgt_rsp_valid;
    logic              cnt_last;
    logic [DATA_W-1:0] tgt_rdata;

    logic              accept;
    logic              issued;
    logic              responded;
    logic              expired;

    assign hit_s1        = (m_addr & S1_MASK) == S1_BASE;
    assign tgt_req_ready = sel_q ? s1_req_ready : s0_req_ready;
    assign tgt_rsp_valid = sel_q ? s1_rsp_valid : s0_rsp_valid;
    // cnt counts completed waiting cycles; the last one fires the timeout.
    assign cnt_last      = (cnt_q + CNT_W'(1)) == CNT_LIMIT;

    mul2t1 #(
        .data_width(DATA_W)
    ) u_rdata_mux (
        .sel(sel_q),
        .d0 (s0_rdata),
        .d1 (s1_rdata),
        .y  (tgt_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        issued     = 1'b0;
        responded  = 1'b0;
        expired    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m_req_valid && ready_q) begin
                    accept     = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tgt_req_ready) begin
                    issued     = 1'b1;
                    next_state = ST_WAIT;
                end else if (cnt_last) begin
                    expired    = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (tgt_rsp_valid) begin
                    responded  = 1'b1;
                    next_state = ST_DONE;
                end else if (cnt_last) begin
                    expired    = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ready is registered so it stays low for the whole reset and rises at
    // the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= (next_state == ST_IDLE);

            if (accept) begin
                sel_q   <= hit_s1;
                addr_q  <= m_addr;
                wen_q   <= m_wen;
                be_q    <= m_be;
                wdata_q <= m_wdata;
            end

            if (accept || issued) begin
                cnt_q <= '0;
            end else if (state == ST_ISSUE || state == ST_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (responded) begin
                rdata_q <= wen_q ? '0 : tgt_rdata;
                err_q   <= 1'b0;
            end else if (expired) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (state == ST_DONE) begin
                err_q   <= 1'b0;
            end
        end
    end

    assign m_req_ready  = ready_q;
    assign m_rsp_valid  = (state == ST_DONE);
    assign m_rsp_err    = err_q;
    assign m_rdata      = rdata_q;

    assign s0_req_valid = (state == ST_ISSUE) && !sel_q;
    assign s1_req_valid = (state == ST_ISSUE) && sel_q;

    // Both targets see the same held copy; only the valid is steered.
    assign s0_addr  = addr_q;
    assign s0_wen   = wen_q;
    assign s0_be    = be_q;
    assign s0_wdata = wdata_q;
    assign s1_addr  = addr_q;
    assign s1_wen   = wen_q;
    assign s1_be    = be_q;
    assign s1_wdata = wdata_q;

    assign fsm_state = state;

endmodule
